// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int unsigned DEFAULT_SIZE  = 32;
  localparam int unsigned DEFAULT_CNT_W = 16;

  localparam logic OUT0 = 1'b0;
  localparam logic OUT1 = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output holding register with valid/ready handshake.
// Optional completed-transfer counter is built only when DEMUX_COUNT_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned size  = DEFAULT_SIZE,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [size-1:0]  i_data,
  input  logic             i_ready,
  output logic             o_free,
  output logic             o_valid,
  output logic [size-1:0]  o_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  logic            r_valid;
  logic [size-1:0] r_data;
  logic            w_fire;

  assign w_fire  = r_valid & i_ready;
  // The slot can accept when empty or when it drains in this same cycle.
  assign o_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_fire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/demux_1to2_pipe.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream to one of two slots.
// Define DEMUX_COUNT_EN to add per-output completed-transfer counters (cnt0_o/cnt1_o).
module demux_1to2_pipe
  import demux_pkg::*;
#(
  parameter int unsigned size  = DEFAULT_SIZE,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic [size-1:0]  data1_o,
  output logic             valid0_o,
  output logic             valid1_o,
  input  logic             ready0_i,
  input  logic             ready1_i
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
`endif
);

  logic w_free0;
  logic w_free1;
  logic w_fire_in;
  logic w_load0;
  logic w_load1;

  // Ready depends only on the selected slot, so a stalled consumer blocks only its own traffic.
  assign ready_o   = (select_i == OUT1) ? w_free1 : w_free0;
  assign w_fire_in = valid_i & ready_o;
  assign w_load0   = w_fire_in & (select_i == OUT0);
  assign w_load1   = w_fire_in & (select_i == OUT1);

  demux_slot #(
    .size  (size),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load0),
    .i_data  (data_i),
    .i_ready (ready0_i),
    .o_free  (w_free0),
    .o_valid (valid0_o),
    .o_data  (data0_o)
`ifdef DEMUX_COUNT_EN
    ,
    .o_cnt   (cnt0_o)
`endif
  );

  demux_slot #(
    .size  (size),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load1),
    .i_data  (data_i),
    .i_ready (ready1_i),
    .o_free  (w_free1),
    .o_valid (valid1_o),
    .o_data  (data1_o)
`ifdef DEMUX_COUNT_EN
    ,
    .o_cnt   (cnt1_o)
`endif
  );

endmodule

// File: doc/demux_1to2_pipe.md
# demux_1to2_pipe

Registered 1-to-2 demultiplexer for the pipelined CPU datapath: one producer stream is steered to one of two consumer streams by `select_i`. It performs the opposite function of the datapath 2-to-1 selectors. Each output has a one-entry holding register with a valid/ready handshake, so a stalled consumer back-pressures only the transfers aimed at it. Typical use is dispatching a result bus to two downstream pipeline stages, for example write-back versus store path.

## Interface
- `size`, default 32: data width in bits.
- `CNT_W`, default 16: transfer-counter width; used only with `DEMUX_COUNT_EN`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `data_i` input `size`: input payload.
- `select_i` input 1: destination; 0 selects output 0, 1 selects output 1. Sampled together with `data_i`.
- `valid_i` input 1: input payload valid.
- `ready_o` output 1: the block can accept the input this cycle.
- `data0_o`, `data1_o` output `size`: registered payload per output.
- `valid0_o`, `valid1_o` output 1: output slot holds valid data.
- `ready0_i`, `ready1_i` input 1: consumer accepts the slot contents.
- `cnt0_o`, `cnt1_o` output `CNT_W`: completed output transfers. These ports exist only with `DEMUX_COUNT_EN`.

## Operation
- Each output k has a slot holding `valid_k` and `data_k`.
- Input fire: `valid_i & ready_o`.
- Output-k fire: `valid_k & ready_k_i`.
- `ready_o` is `~valid_S | ready_S_i`, where S = `select_i`. It is combinational from `select_i` and the selected consumer's ready; there is no registered path from `valid_i` to `ready_o`.
- On input fire, slot S loads `data_i` and sets `valid_S`.
- On output-k fire with no load into slot k, `valid_k` clears.
- Simultaneous output-k fire and load into k: the slot takes the new data and `valid_k` stays 1. This is full throughput, one transfer per cycle per output.
- The non-selected slot drains independently in the same cycle.
- `data_k` is held stable while `valid_k & ~ready_k_i`. The consumer sees the data unchanged until it accepts.
- `data_k` is don't-care while `valid_k = 0`, but is never X after reset.
- Ordering: in-order per output. There is no ordering guarantee between output 0 and output 1.
- `select_i` is ignored when `valid_i = 0`. `ready_o` still reflects the current `select_i`.

## Timing
- Latency: data accepted in cycle n appears on `data_S_o` with `valid_S_o = 1` in cycle n+1.
- Throughput: 1 transfer per cycle when the selected consumer holds ready high.
- Reset values:
  - `valid0_o = valid1_o = 0`
  - `data0_o = data1_o = 0`
  - `cnt0_o = cnt1_o = 0`
  - `ready_o = 1` in the first cycle after reset.
- Reset mid-operation: pending slot contents are discarded with no output fire. An input fire in the same cycle as `rst_i` is dropped.
- Slot full with consumer stalled: `ready_o = 0` for that select value only. Traffic to the other output continues.
- Counter wrap: all ones plus 1 gives 0. There is no saturation and no flag.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - Ports `cnt0_o` and `cnt1_o` are present.
  - Each counter increments by 1 on every output-k fire, with modulo 2^`CNT_W` wrap.
- `DEMUX_COUNT_EN` undefined:
  - The counter ports and registers are absent.
  - Datapath and handshake behaviour are bit-identical to the defined case.

## Structure
- Shared package `demux_pkg` holds:
  - the default `size` and `CNT_W` constants;
  - output-index localparams `OUT0 = 1'b0` and `OUT1 = 1'b1`.
- One sub-module, `demux_slot`: a single-entry holding register with load, valid, ready and optional counter. The top instantiates it twice and adds the ready/select steering.

## Test plan
- Reset, then `valid_i=1`, `select_i=0`, `data_i=32'hDEADBEEF`, `ready0_i=1`. Required: `ready_o=1`; next cycle `valid0_o=1` and `data0_o=32'hDEADBEEF`; `valid1_o` stays 0.
- Stream 8 words to output 1 with `ready1_i=1`. Required: 8 consecutive output fires, 1-cycle latency, no bubbles; `cnt1_o=8` with `DEMUX_COUNT_EN`.
- Hold `ready0_i=0` after one word (32'h1) is loaded into slot 0. Required:
  - `ready_o=0` with `select_i=0` and `ready_o=1` with `select_i=1`;
  - a word 32'h2 sent to output 1 appears there;
  - `data0_o` stays 32'h1 until `ready0_i` rises.
- Slot 0 full with `ready0_i=1` and a new input to output 0 in the same cycle. Required: `valid0_o` remains 1 and the next cycle shows the new data.
- Assert `rst_i` while both slots are valid. Required: next cycle both valid outputs are 0, both data outputs are 0, both counters are 0, and no output fire occurs.
- With `DEMUX_COUNT_EN` and `CNT_W=4`: 17 fires on output 0. Required: `cnt0_o=1` after the wrap.
